mc_main_fsm: RTL and testbench
==============================

# mc_main_fsm

Multi-cycle main control FSM for the MIPS-style datapath; second-generation controller decoding the full base instruction subset (R-type, LW, SW, BEQ, BNE, ADDI, ORI, J). Adds a memory-ready wait handshake, conditional-branch write qualification, and an optional illegal-opcode trap. Sits between the instruction register opcode field and all datapath mux/enable controls, alongside the ALU decoder.

## Interface
- OPCODE_W, 6, opcode field width
- ALUOP_W, 3, width of alu_op (>=2; upper bits zero-padded)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- opcode  in  OPCODE_W  instruction opcode from IR
- mem_ready  in  1  memory access completes this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  memory write strobe
- ior_d  out  1  0 = PC address, 1 = ALUOut address
- ir_write  out  1  IR load enable
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero matches branch_ne
- branch_ne  out  1  0 = take on zero (BEQ), 1 = take on non-zero (BNE)
- pc_src  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 EXC_VECTOR
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  00 rt, 01 const 4, 10 imm, 11 imm<<2
- alu_op  out  ALUOP_W  0 add, 1 sub, 2 funct, 3 or
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write
- imm_zext  out  1  zero-extend immediate (ORI)
- state_o  out  4  current state, debug
- exc  out  1  trap pulse (only with MC_FSM_EXC_EN; else tied 0)

## Operation
- States: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, IMMWB 10, JUMP 11, ORIEX 12, EXC 13.
- All outputs are Moore decodes of state, except ir_write/pc_write in FETCH (qualified by mem_ready). Unlisted outputs are 0 in every state; no X.
- FETCH: mem_req, ior_d=0, alu_src_a=0, alu_src_b=01, alu_op=0, pc_src=00; ir_write=pc_write=mem_ready. mem_ready -> DECODE, else stay.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=0 (branch target into ALUOut). Next by opcode: 0x00 EXEC, 0x23/0x2B MEMADR, 0x04/0x05 BRANCH, 0x08 ADDIEX, 0x0D ORIEX, 0x02 JUMP, other -> illegal handling.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=0; LW -> MEMRD, SW -> MEMWR (opcode held stable by IR).
- MEMRD: mem_req, ior_d=1; mem_ready -> MEMWB. MEMWB: reg_write, mem_to_reg=1, reg_dst=0 -> FETCH.
- MEMWR: mem_req, mem_write, ior_d=1; mem_ready -> FETCH. mem_write held until accepted.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=2 -> ALUWB. ALUWB: reg_write, reg_dst=1 -> FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=0 -> IMMWB. ORIEX: same with alu_op=3, imm_zext=1 -> IMMWB. IMMWB: reg_write, reg_dst=0 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=1, pc_write_cond, pc_src=01, branch_ne=opcode[0] -> FETCH.
- JUMP: pc_write, pc_src=10 -> FETCH.

## Timing
- Reset: state=FETCH immediately on rst_n low; outputs = FETCH decode (mem_req=1, ir_write=pc_write=0 while mem_ready=0). Reset mid-instruction aborts it; no partial reg_write/mem_write after deassert.
- CPI: R/ADDI/ORI 4, BRANCH/J 3, SW 4, LW 5, plus one cycle per mem_ready=0 cycle in FETCH/MEMRD/MEMWR.
- mem_ready ignored outside FETCH/MEMRD/MEMWR.
- alu_op driven as zero-extended 2-bit code to ALUOP_W.

## Configuration
- MC_FSM_EXC_EN defined: illegal opcode in DECODE -> EXC; EXC asserts exc=1, pc_write=1, pc_src=11 for exactly one cycle -> FETCH.
- Undefined: illegal opcode in DECODE -> FETCH (treated as NOP, 2 cycles); EXC unreachable, exc tied 0, pc_src=11 never driven.

## Test plan
- Reset mid-MEMWR, then release with opcode=0x2B -> state_o=0, mem_write=0 at first post-reset edge, mem_req=1.
- opcode=0x00, mem_ready=1 always -> state_o 0,1,6,7,0; reg_write=1 and reg_dst=1 only in cycle 4.
- opcode=0x23, mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, total 8 cycles, mem_to_reg=1 with reg_write in MEMWB.
- opcode=0x05 -> BRANCH with pc_write_cond=1, branch_ne=1, alu_op=1, pc_src=01; opcode=0x04 gives branch_ne=0.
- opcode=0x0D -> ORIEX alu_op=3, imm_zext=1, then IMMWB reg_write=1, reg_dst=0.
- opcode=0x3F: with MC_FSM_EXC_EN -> state 13, exc=1, pc_src=11 one cycle; without -> FETCH after DECODE, exc=0.

Source files
------------

// File: rtl/mc_main_fsm.sv
// mc_main_fsm: multi-cycle main control FSM for the MIPS-style datapath.
// It decodes the IR opcode field (R-type, LW, SW, BEQ, BNE, ADDI, ORI, J)
// and drives every datapath mux select and enable. There is a mem_ready
// handshake in FETCH, MEMRD and MEMWR.
//
// Optional build macro: MC_FSM_EXC_EN
//   Defined   - an illegal opcode traps through EXC: exc=1, pc_write=1 and
//               pc_src=11 for one cycle.
//   Undefined - an illegal opcode returns to FETCH and acts as a NOP. exc
//               is always 0 and pc_src never takes the value 11.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   opcode               IR opcode field
//   mem_ready            memory access completes this cycle
//   mem_req, mem_write   memory request / write strobe
//   ior_d                memory address select (0 PC, 1 ALUOut)
//   ir_write, pc_write   IR load, unconditional PC load
//   pc_write_cond        PC load qualified by ALU zero vs branch_ne
//   branch_ne            branch sense (0 BEQ, 1 BNE)
//   pc_src               00 ALU, 01 ALUOut, 10 jump, 11 exception vector
//   alu_src_a/_b, alu_op ALU operand selects and operation code
//   reg_dst, mem_to_reg  register write address / data selects
//   reg_write, imm_zext  register file write, zero-extend immediate
//   state_o              current state (debug)
//   exc                  trap pulse
//
// state  | meaning
// FETCH  | read instruction at PC, PC+4 ; wait mem_ready
// DECODE | read regs, branch target into ALUOut
// MEMADR | effective address for LW/SW
// MEMRD  | data read ; wait mem_ready
// MEMWB  | load result into rt
// MEMWR  | data write ; wait mem_ready
// EXEC   | R-type ALU operation
// ALUWB  | R-type result into rd
// BRANCH | compare and conditional PC load
// ADDIEX | rs + sign-extended imm
// IMMWB  | immediate result into rt
// JUMP   | PC <- jump target
// ORIEX  | rs | zero-extended imm
// EXC    | trap to exception vector
module mc_main_fsm #(
   parameter int OPCODE_W = 6,
   parameter int ALUOP_W  = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                mem_write,
   output logic                ior_d,
   output logic                ir_write,
   output logic                pc_write,
   output logic                pc_write_cond,
   output logic                branch_ne,
   output logic [1:0]          pc_src,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [ALUOP_W-1:0]  alu_op,
   output logic                reg_dst,
   output logic                mem_to_reg,
   output logic                reg_write,
   output logic                imm_zext,
   output logic [3:0]          state_o,
   output logic                exc
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_IMMWB  = 4'd10, S_JUMP   = 4'd11,
      S_ORIEX  = 4'd12, S_EXC    = 4'd13
   } state_t;

   typedef struct packed {
      logic       mem_req;
      logic       mem_write;
      logic       ior_d;
      logic       pc_write;
      logic       pc_write_cond;
      logic       branch_ne;
      logic [1:0] pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       imm_zext;
      logic       exc;
      logic       fetch;
   } ctrl_t;

   localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'h00);
   localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'h02);
   localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'h04);
   localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'h05);
   localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'h08);
   localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(6'h0D);
   localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'h23);
   localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'h2B);

   function automatic state_t next_state(state_t s, logic [OPCODE_W-1:0] op,
                                         logic rdy);
      state_t n;
      n = S_FETCH;
      case (s)
         S_FETCH:  n = rdy ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_RTYPE:      n = S_EXEC;
               OP_LW, OP_SW:  n = S_MEMADR;
               OP_BEQ, OP_BNE: n = S_BRANCH;
               OP_ADDI:       n = S_ADDIEX;
               OP_ORI:        n = S_ORIEX;
               OP_J:          n = S_JUMP;
`ifdef MC_FSM_EXC_EN
               default:       n = S_EXC;
`else
               default:       n = S_FETCH;
`endif
            endcase
         end
         S_MEMADR: n = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  n = rdy ? S_MEMWB : S_MEMRD;
         S_MEMWR:  n = rdy ? S_FETCH : S_MEMWR;
         S_EXEC:   n = S_ALUWB;
         S_ADDIEX: n = S_IMMWB;
         S_ORIEX:  n = S_IMMWB;
         default:  n = S_FETCH;
      endcase
      return n;
   endfunction

   // Moore decode. It is evaluated on the next state, so the registered
   // outputs line up with the state register. branch_ne is captured from
   // opcode[0] on entry to BRANCH. The IR holds opcode stable across the
   // instruction.
   function automatic ctrl_t decode(state_t s, logic op0);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH:  begin c.mem_req = 1'b1; c.alu_src_b = 2'b01; c.fetch = 1'b1; end
         S_DECODE: c.alu_src_b = 2'b11;
         S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
         S_MEMRD:  begin c.mem_req = 1'b1; c.ior_d = 1'b1; end
         S_MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
         S_MEMWR:  begin c.mem_req = 1'b1; c.mem_write = 1'b1; c.ior_d = 1'b1; end
         S_EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 2'd2; end
         S_ALUWB:  begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
         S_BRANCH: begin
            c.alu_src_a = 1'b1; c.alu_op = 2'd1; c.pc_write_cond = 1'b1;
            c.pc_src = 2'b01; c.branch_ne = op0;
         end
         S_ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
         S_ORIEX:  begin
            c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 2'd3;
            c.imm_zext = 1'b1;
         end
         S_IMMWB:  c.reg_write = 1'b1;
         S_JUMP:   begin c.pc_write = 1'b1; c.pc_src = 2'b10; end
`ifdef MC_FSM_EXC_EN
         S_EXC:    begin c.exc = 1'b1; c.pc_write = 1'b1; c.pc_src = 2'b11; end
`endif
         default:  c = '0;
      endcase
      return c;
   endfunction

   state_t state, state_nxt;
   ctrl_t  ctrl;

   always_comb state_nxt = next_state(state, opcode, mem_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_FETCH;
         ctrl  <= decode(S_FETCH, 1'b0);
      end else begin
         state <= state_nxt;
         ctrl  <= decode(state_nxt, opcode[0]);
      end
   end

   // FETCH loads the IR and PC only when the instruction read completes.
   assign ir_write      = ctrl.fetch & mem_ready;
   assign pc_write      = ctrl.pc_write | (ctrl.fetch & mem_ready);
   assign mem_req       = ctrl.mem_req;
   assign mem_write     = ctrl.mem_write;
   assign ior_d         = ctrl.ior_d;
   assign pc_write_cond = ctrl.pc_write_cond;
   assign branch_ne     = ctrl.branch_ne;
   assign pc_src        = ctrl.pc_src;
   assign alu_src_a     = ctrl.alu_src_a;
   assign alu_src_b     = ctrl.alu_src_b;
   assign alu_op        = ALUOP_W'(ctrl.alu_op);
   assign reg_dst       = ctrl.reg_dst;
   assign mem_to_reg    = ctrl.mem_to_reg;
   assign reg_write     = ctrl.reg_write;
   assign imm_zext      = ctrl.imm_zext;
   assign exc           = ctrl.exc;
   assign state_o       = state;

endmodule

// File: tb/tb_mc_main_fsm.sv
// Testbench for mc_main_fsm. It pushes the expected per-cycle state sequence
// of each instruction to a queue, then pops one entry per clock. Each entry
// is compared against state_o and the full control word.
module tb_mc_main_fsm;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       mem_req, mem_write, ior_d, ir_write, pc_write, pc_write_cond;
   logic       branch_ne, alu_src_a, reg_dst, mem_to_reg, reg_write, imm_zext, exc;
   logic [1:0] pc_src, alu_src_b;
   logic [2:0] alu_op;
   logic [3:0] state_o;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [3:0] st;
      logic       rdy;
   } item_t;

   item_t exp_q[$];

   mc_main_fsm #(.OPCODE_W(6), .ALUOP_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_write(mem_write), .ior_d(ior_d),
      .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .branch_ne(branch_ne), .pc_src(pc_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .imm_zext(imm_zext),
      .state_o(state_o), .exc(exc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [19:0] ctrl_word();
      return {mem_req, mem_write, ior_d, ir_write, pc_write, pc_write_cond,
              branch_ne, pc_src, alu_src_a, alu_src_b, alu_op, reg_dst,
              mem_to_reg, reg_write, imm_zext, exc};
   endfunction

   // Expected controls per state, listed directly from the state descriptions.
   function automatic logic [19:0] exp_word(input logic [3:0] st, input logic [5:0] op,
                                            input logic rdy);
      logic mr, mw, iord, irw, pcw, pwc, bne, asa, rd, m2r, rw, iz, ex;
      logic [1:0] pcs, asb;
      logic [2:0] aop;
      {mr, mw, iord, irw, pcw, pwc, bne, asa, rd, m2r, rw, iz, ex} = '0;
      pcs = 2'd0; asb = 2'd0; aop = 3'd0;
      case (st)
         4'd0:  begin mr = 1; asb = 2'd1; irw = rdy; pcw = rdy; end
         4'd1:  asb = 2'd3;
         4'd2:  begin asa = 1; asb = 2'd2; end
         4'd3:  begin mr = 1; iord = 1; end
         4'd4:  begin rw = 1; m2r = 1; end
         4'd5:  begin mr = 1; mw = 1; iord = 1; end
         4'd6:  begin asa = 1; aop = 3'd2; end
         4'd7:  begin rw = 1; rd = 1; end
         4'd8:  begin asa = 1; aop = 3'd1; pwc = 1; pcs = 2'd1; bne = op[0]; end
         4'd9:  begin asa = 1; asb = 2'd2; end
         4'd10: rw = 1;
         4'd11: begin pcw = 1; pcs = 2'd2; end
         4'd12: begin asa = 1; asb = 2'd2; aop = 3'd3; iz = 1; end
         4'd13: begin ex = 1; pcw = 1; pcs = 2'd3; end
         default: ;
      endcase
      return {mr, mw, iord, irw, pcw, pwc, bne, pcs, asa, asb, aop, rd, m2r, rw, iz, ex};
   endfunction

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   // Expected sequence for one instruction. fs/ms count the mem_ready=0 cycles
   // in FETCH and in MEMRD/MEMWR. When abort is set, the final accepting
   // cycle of the memory access is left out.
   task automatic push_instr(input logic [5:0] op, input int fs, input int ms,
                             input bit abort);
      for (int i = 0; i < fs; i++) exp_q.push_back('{4'd0, 1'b0});
      exp_q.push_back('{4'd0, 1'b1});
      exp_q.push_back('{4'd1, rnd()});
      case (op)
         6'h00: begin exp_q.push_back('{4'd6, rnd()}); exp_q.push_back('{4'd7, rnd()}); end
         6'h23, 6'h2B: begin
            exp_q.push_back('{4'd2, rnd()});
            for (int i = 0; i < ms; i++)
               exp_q.push_back('{(op == 6'h23) ? 4'd3 : 4'd5, 1'b0});
            if (!abort) exp_q.push_back('{(op == 6'h23) ? 4'd3 : 4'd5, 1'b1});
            if (op == 6'h23) exp_q.push_back('{4'd4, rnd()});
         end
         6'h04, 6'h05: exp_q.push_back('{4'd8, rnd()});
         6'h08: begin exp_q.push_back('{4'd9, rnd()}); exp_q.push_back('{4'd10, rnd()}); end
         6'h0D: begin exp_q.push_back('{4'd12, rnd()}); exp_q.push_back('{4'd10, rnd()}); end
         6'h02: exp_q.push_back('{4'd11, rnd()});
         default: begin
`ifdef MC_FSM_EXC_EN
            exp_q.push_back('{4'd13, rnd()});
`endif
         end
      endcase
   endtask

   // Drives and checks the queued cycles. It starts one time unit after a
   // rising edge.
   task automatic run_instr(input logic [5:0] op, input int fs, input int ms,
                            input bit abort);
      item_t it;
      opcode = op;
      push_instr(op, fs, ms, abort);
      while (exp_q.size() > 0) begin
         it = exp_q.pop_front();
         mem_ready = it.rdy;
         @(negedge clk);
         chk($sformatf("state op=%02h", op), 32'(state_o), 32'(it.st));
         chk($sformatf("ctrl op=%02h st=%0d", op, it.st), 32'(ctrl_word()),
             32'(exp_word(it.st, op, it.rdy)));
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      opcode = 6'h00;
      mem_ready = 1'b0;
      #12;
      chk("reset_state", 32'(state_o), 32'd0);
      chk("reset_ctrl", 32'(ctrl_word()), 32'(exp_word(4'd0, 6'h00, 1'b0)));
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_instr(6'h00, 0, 0, 1'b0);
      run_instr(6'h23, 1, 3, 1'b0);
      run_instr(6'h05, 0, 0, 1'b0);
      run_instr(6'h04, 2, 0, 1'b0);
      run_instr(6'h0D, 0, 0, 1'b0);
      run_instr(6'h08, 0, 0, 1'b0);
      run_instr(6'h02, 0, 0, 1'b0);
      run_instr(6'h2B, 0, 2, 1'b0);
      run_instr(6'h3F, 0, 0, 1'b0);
      run_instr(6'h23, 0, 0, 1'b0);

      // Abort a store that is stalled in MEMWR.
      run_instr(6'h2B, 0, 2, 1'b1);
      chk("pre_abort_state", 32'(state_o), 32'd5);
      mem_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("abort_state", 32'(state_o), 32'd0);
      chk("abort_mem_write", 32'(mem_write), 32'd0);
      chk("abort_mem_req", 32'(mem_req), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_state", 32'(state_o), 32'd0);
      chk("post_rst_mem_write", 32'(mem_write), 32'd0);
      chk("post_rst_mem_req", 32'(mem_req), 32'd1);
      chk("post_rst_reg_write", 32'(reg_write), 32'd0);

      // A mix of instructions with random stalls.
      for (int n = 0; n < 30; n++) begin
         logic [5:0] ops [9];
         ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h02, 6'h3F};
         run_instr(ops[$urandom_range(0, 8)], $urandom_range(0, 2),
                   $urandom_range(0, 3), 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
